cordic_arbiter: RTL

//  Shares one cordic_pipelined sine/cosine engine among NUM_REQ requesters.

---
 rtl/cordic_arbiter_if.sv | 24 ++
 rtl/cordic_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/cordic_arbiter_if.sv
// Client-side bundle for cordic_arbiter: angle requests in, tagged sine/cosine results out.
interface cordic_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_angle;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           rsp_sine;
  logic [15:0]           rsp_cosine;
  logic                  busy;

  modport master (
    output req_valid, req_angle,
    input  req_ready, rsp_valid, rsp_id, rsp_sine, rsp_cosine, busy
  );

  modport slave (
    input  req_valid, req_angle,
    output req_ready, rsp_valid, rsp_id, rsp_sine, rsp_cosine, busy
  );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin front end for a shared pipelined CORDIC sine/cosine engine.
// Folds angles into +/-90 deg, tags each issue and un-folds the result on return.
module cordic_arbiter #(
  parameter int          NUM_REQ  = 4,
  parameter int          PIPE_LAT = 16,
  parameter logic [15:0] X_INIT   = 16'h26DD
) (
  input  logic                  clock,
  input  logic                  reset,
  cordic_arbiter_if.slave       bus,
  output logic [15:0]           cordic_x_start,
  output logic [15:0]           cordic_y_start,
  output logic [15:0]           cordic_angle,
  input  logic [15:0]           cordic_sine,
  input  logic [15:0]           cordic_cosine
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]               ptr;
  logic [ID_W-1:0]               cand;
  logic [ID_W-1:0]               gnt_idx;
  logic                          xfer;
  logic [NUM_REQ-1:0]            grant;
  logic [15:0]                   sel_angle;
  logic [15:0]                   fold_angle;
  logic                          fold_neg;
  logic [PIPE_LAT:0]             tag_v;
  logic [PIPE_LAT:0]             tag_neg;
  logic [PIPE_LAT:0][ID_W-1:0]   tag_id;
  logic                          rsp_valid;
  logic [ID_W-1:0]               rsp_id;
  logic [15:0]                   rsp_sine;
  logic [15:0]                   rsp_cosine;

  function automatic logic [15:0] neg_sat(input logic [15:0] v);
    return (v == 16'h8000) ? 16'h7FFF : (~v + 16'd1);
  endfunction

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    cand    = '0;
    xfer    = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!xfer && bus.req_valid[cand]) begin
        xfer    = 1'b1;
        gnt_idx = cand;
      end
    end
    if (xfer) grant[gnt_idx] = 1'b1;
  end

  // Quadrants 01/10 lie outside +/-90 deg: rotate by 180 and negate the result later.
  always_comb begin
    sel_angle  = bus.req_angle[16*gnt_idx +: 16];
    fold_neg   = sel_angle[15] ^ sel_angle[14];
    fold_angle = fold_neg ? {~sel_angle[15], sel_angle[14:0]} : sel_angle;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr            <= ID_W'(NUM_REQ - 1);
      cordic_x_start <= X_INIT;
      cordic_y_start <= '0;
      cordic_angle   <= '0;
    end else if (xfer) begin
      ptr            <= gnt_idx;
      cordic_x_start <= X_INIT;
      cordic_y_start <= '0;
      cordic_angle   <= fold_angle;
    end
  end

  // Tag chain tracks the engine pipeline; reset empties it even though the engine keeps running.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_v   <= '0;
      tag_neg <= '0;
      tag_id  <= '0;
    end else begin
      tag_v   <= {tag_v[PIPE_LAT-1:0], xfer};
      tag_neg <= {tag_neg[PIPE_LAT-1:0], fold_neg};
      tag_id  <= {tag_id[PIPE_LAT-1:0], gnt_idx};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sine   <= '0;
      rsp_cosine <= '0;
    end else begin
      rsp_valid <= tag_v[PIPE_LAT];
      if (tag_v[PIPE_LAT]) begin
        rsp_id     <= tag_id[PIPE_LAT];
        rsp_sine   <= tag_neg[PIPE_LAT] ? neg_sat(cordic_sine)   : cordic_sine;
        rsp_cosine <= tag_neg[PIPE_LAT] ? neg_sat(cordic_cosine) : cordic_cosine;
      end
    end
  end

  assign bus.req_ready  = grant;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_sine   = rsp_sine;
  assign bus.rsp_cosine = rsp_cosine;
  assign bus.busy       = (|tag_v) | rsp_valid;
endmodule
